// File: rtl/alu16_arbiter.sv
// alu16_arbiter
// Two-client round-robin arbiter and sequencer for a shared, purely
// combinational 16-bit signed ALU. The winner's operands are registered
// onto alu_*, the ALU result is captured one cycle later into res_*, and
// a one-cycle done pulse is returned to the client that was served.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req0/req1                   operation request per client
//   n0,m0,opc0,c0 / n1,m1,...   operands, opcode and carry-in per client
//   alu_n,alu_m,alu_opc,alu_c   registered operands driven to the ALU
//   alu_f,alu_zer,alu_neg       combinational ALU result and flags
//   gnt                         one-hot grant, held from grant through DONE
//   done0/done1                 one-cycle result-valid pulse per client
//   res_f,res_zer,res_neg       captured result, held until next capture
//   busy                        high whenever the sequencer is not idle
module alu16_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] n0,
    input  logic [15:0] m0,
    input  logic [15:0] n1,
    input  logic [15:0] m1,
    input  logic [2:0]  opc0,
    input  logic [2:0]  opc1,
    input  logic        c0,
    input  logic        c1,
    output logic [15:0] alu_n,
    output logic [15:0] alu_m,
    output logic [2:0]  alu_opc,
    output logic        alu_c,
    input  logic [15:0] alu_f,
    input  logic        alu_zer,
    input  logic        alu_neg,
    output logic [1:0]  gnt,
    output logic        done0,
    output logic        done1,
    output logic [15:0] res_f,
    output logic        res_zer,
    output logic        res_neg,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    logic   ptr;   // client favoured when both request
    logic   pick;  // client that wins if a grant happens this cycle

    // A lone requester always wins; on contention the pointer decides.
    always_comb begin
        if (req0 && req1)
            pick = ptr;
        else
            pick = req1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= 1'b0;
            gnt     <= '0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            alu_n   <= '0;
            alu_m   <= '0;
            alu_opc <= '0;
            alu_c   <= 1'b0;
            res_f   <= '0;
            res_zer <= 1'b0;
            res_neg <= 1'b0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        if (pick) begin
                            alu_n   <= n1;
                            alu_m   <= m1;
                            alu_opc <= opc1;
                            alu_c   <= c1;
                            gnt     <= 2'b10;
                        end else begin
                            alu_n   <= n0;
                            alu_m   <= m0;
                            alu_opc <= opc0;
                            alu_c   <= c0;
                            gnt     <= 2'b01;
                        end
                        ptr   <= ~pick;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    res_f   <= alu_f;
                    res_zer <= alu_zer;
                    res_neg <= alu_neg;
                    done0   <= gnt[0];
                    done1   <= gnt[1];
                    state   <= DONE;
                end
                DONE: begin
                    gnt   <= '0;
                    state <= IDLE;
                end
                default: begin
                    gnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu16_arbiter.sv
// tb_alu16_arbiter
// Self-checking bench for alu16_arbiter with an ALU stub f = n+m+c.
// Expected grants follow the round-robin rule kept in m_ptr; expected
// results are computed from the operands presented at grant time.
module tb_alu16_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1;
    logic [15:0] n0, m0, n1, m1;
    logic [2:0]  opc0, opc1;
    logic        c0, c1;
    logic [15:0] alu_n, alu_m;
    logic [2:0]  alu_opc;
    logic        alu_c;
    logic [15:0] alu_f;
    logic        alu_zer, alu_neg;
    logic [1:0]  gnt;
    logic        done0, done1;
    logic [15:0] res_f;
    logic        res_zer, res_neg;
    logic        busy;

    int checks = 0;
    int failures = 0;
    logic m_ptr;

    always #5 clk = ~clk;

    assign alu_f   = alu_n + alu_m + {15'd0, alu_c};
    assign alu_zer = (alu_f == 16'd0);
    assign alu_neg = alu_f[15];

    alu16_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .n0(n0), .m0(m0), .n1(n1), .m1(m1),
        .opc0(opc0), .opc1(opc1), .c0(c0), .c1(c1),
        .alu_n(alu_n), .alu_m(alu_m), .alu_opc(alu_opc), .alu_c(alu_c),
        .alu_f(alu_f), .alu_zer(alu_zer), .alu_neg(alu_neg),
        .gnt(gnt), .done0(done0), .done1(done1),
        .res_f(res_f), .res_zer(res_zer), .res_neg(res_neg),
        .busy(busy)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Stimulus helper: runs one grant/exec/done round from an IDLE negedge
    // and returns what was observed; callers do the comparisons.
    task automatic do_op(input bit drop, input bit poke,
                         output logic [1:0] g_exec, output logic [2:0] opc_exec,
                         output logic [1:0] dn, output logic [15:0] f,
                         output logic z, output logic ng, output int busy_cnt,
                         output logic [1:0] g_after, output logic [1:0] dn_after);
        busy_cnt = 0;
        @(posedge clk); @(negedge clk);
        g_exec = gnt; opc_exec = alu_opc; busy_cnt += int'(busy);
        if (poke) n0 = 16'd100;
        @(posedge clk); @(negedge clk);
        dn = {done1, done0}; f = res_f; z = res_zer; ng = res_neg;
        busy_cnt += int'(busy);
        if (drop) begin
            if (done0) req0 = 1'b0;
            if (done1) req1 = 1'b0;
        end
        @(posedge clk); @(negedge clk);
        g_after = gnt; dn_after = {done1, done0}; busy_cnt += int'(busy);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL reset_gnt: got %b want 00", gnt); end
        checks++; if ({done1, done0} !== 2'b00) begin failures++; $display("FAIL reset_done: got %b want 00", {done1, done0}); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if ({alu_n, alu_m, alu_opc, alu_c} !== 36'd0) begin failures++; $display("FAIL reset_alu: got %h want 0", {alu_n, alu_m, alu_opc, alu_c}); end
        checks++; if ({res_f, res_zer, res_neg} !== 18'd0) begin failures++; $display("FAIL reset_res: got %h want 0", {res_f, res_zer, res_neg}); end
    endtask

    task automatic test_single();
        logic [1:0] ge, dn, ga, da; logic [2:0] oe; logic [15:0] f; logic z, ng; int bc;
        req0 = 1'b1; n0 = 16'd8; m0 = 16'd3; opc0 = 3'd0; c0 = 1'b0;
        do_op(1'b1, 1'b0, ge, oe, dn, f, z, ng, bc, ga, da);
        m_ptr = 1'b1;
        checks++; if (ge !== 2'b01) begin failures++; $display("FAIL single_gnt: got %b want 01", ge); end
        checks++; if (dn !== 2'b01) begin failures++; $display("FAIL single_done: got %b want 01", dn); end
        checks++; if ({f, z, ng} !== {16'd11, 1'b0, 1'b0}) begin failures++; $display("FAIL single_res: got %h/%b/%b want 000b/0/0", f, z, ng); end
        checks++; if (bc !== 2) begin failures++; $display("FAIL single_busy: got %0d cycles want 2", bc); end
        checks++; if ({ga, da} !== 4'b0000) begin failures++; $display("FAIL single_after: got gnt=%b done=%b want 00/00", ga, da); end
    endtask

    task automatic test_simultaneous();
        logic [1:0] ge, dn, ga, da; logic [2:0] oe; logic [15:0] f; logic z, ng; int bc;
        logic [1:0] want_g [3];
        want_g[0] = 2'b01; want_g[1] = 2'b10; want_g[2] = 2'b01;
        apply_reset();
        req0 = 1'b1; n0 = 16'd8; m0 = 16'd3; opc0 = 3'd1; c0 = 1'b0;
        req1 = 1'b1; n1 = 16'hFFFB; m1 = 16'd2; opc1 = 3'd2; c1 = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            do_op(i == 2, 1'b0, ge, oe, dn, f, z, ng, bc, ga, da);
            checks++; if (ge !== want_g[i]) begin failures++; $display("FAIL simul_gnt round %0d: got %b want %b", i, ge, want_g[i]); end
            checks++; if (dn !== want_g[i]) begin failures++; $display("FAIL simul_done round %0d: got %b want %b", i, dn, want_g[i]); end
            if (want_g[i] == 2'b01) begin
                checks++; if ({f, ng} !== {16'd11, 1'b0}) begin failures++; $display("FAIL simul_res0 round %0d: got %h/%b want 000b/0", i, f, ng); end
            end else begin
                checks++; if ({f, ng} !== {16'hFFFD, 1'b1}) begin failures++; $display("FAIL simul_res1 round %0d: got %h/%b want fffd/1", i, f, ng); end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        m_ptr = 1'b1;
    endtask

    task automatic test_isolation();
        logic [1:0] ge, dn, ga, da; logic [2:0] oe; logic [15:0] f; logic z, ng; int bc;
        req0 = 1'b1; n0 = 16'd8; m0 = 16'd3; opc0 = 3'd0; c0 = 1'b0;
        do_op(1'b1, 1'b1, ge, oe, dn, f, z, ng, bc, ga, da);
        m_ptr = 1'b1;
        checks++; if (f !== 16'd11) begin failures++; $display("FAIL isolation_res: got %h want 000b", f); end
        checks++; if (alu_n !== 16'd8) begin failures++; $display("FAIL isolation_alu_n: got %h want 0008", alu_n); end
        n0 = 16'd8;
    endtask

    task automatic test_opcode_sweep();
        logic [1:0] ge, dn, ga, da; logic [2:0] oe; logic [15:0] f; logic z, ng; int bc;
        for (int unsigned i = 0; i < 8; i++) begin
            req0 = 1'b1; opc0 = 3'(i); n0 = 16'(i); m0 = 16'd1; c0 = 1'b0;
            do_op(1'b1, 1'b0, ge, oe, dn, f, z, ng, bc, ga, da);
            checks++; if (oe !== 3'(i)) begin failures++; $display("FAIL opc_sweep %0d: got %0d want %0d", i, oe, i); end
        end
        req0 = 1'b1; n0 = 16'd3; m0 = 16'hFFFD; opc0 = 3'd5; c0 = 1'b0;
        do_op(1'b1, 1'b0, ge, oe, dn, f, z, ng, bc, ga, da);
        m_ptr = 1'b1;
        checks++; if ({f, z, ng} !== {16'd0, 1'b1, 1'b0}) begin failures++; $display("FAIL zero_res: got %h/%b/%b want 0000/1/0", f, z, ng); end
    endtask

    task automatic test_late_request();
        req0 = 1'b1; n0 = 16'd1; m0 = 16'd1; c0 = 1'b0;
        @(posedge clk); @(negedge clk);
        req1 = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++; if (done0 !== 1'b1) begin failures++; $display("FAIL late_done0: got %b want 1", done0); end
        req0 = 1'b0; req1 = 1'b0;
        m_ptr = 1'b1;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        checks++; if ({busy, gnt} !== 3'b000) begin failures++; $display("FAIL late_ignored: got busy=%b gnt=%b want 0/00", busy, gnt); end
    endtask

    task automatic test_reset_mid();
        logic [1:0] ge, dn, ga, da; logic [2:0] oe; logic [15:0] f; logic z, ng; int bc;
        logic saw_done;
        req0 = 1'b1; n0 = 16'd8; m0 = 16'd3; opc0 = 3'd6; c0 = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_pre_busy: got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if ({gnt, done0, done1, busy} !== 5'd0) begin failures++; $display("FAIL mid_ctrl: got %b want 00000", {gnt, done0, done1, busy}); end
        checks++; if ({alu_n, alu_m, alu_opc, alu_c, res_f, res_zer, res_neg} !== 54'd0) begin failures++; $display("FAIL mid_data: got %h want 0", {alu_n, alu_m, alu_opc, alu_c, res_f, res_zer, res_neg}); end
        req0 = 1'b0;
        saw_done = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            saw_done |= done0 | done1;
            if (i == 1) rst_n = 1'b1;
        end
        m_ptr = 1'b0;
        checks++; if (saw_done !== 1'b0) begin failures++; $display("FAIL mid_no_done: got %b want 0", saw_done); end
        // req1 alone after reset is served
        req1 = 1'b1; n1 = 16'd20; m1 = 16'd22; opc1 = 3'd3; c1 = 1'b1;
        do_op(1'b1, 1'b0, ge, oe, dn, f, z, ng, bc, ga, da);
        m_ptr = 1'b0;
        checks++; if ({ge, dn, f} !== {2'b10, 2'b10, 16'd43}) begin failures++; $display("FAIL mid_req1_only: got gnt=%b done=%b f=%h want 10/10/002b", ge, dn, f); end
        // pointer toward client 1, then reset: both requesting favours client 0
        req0 = 1'b1; n0 = 16'd8; m0 = 16'd3; c0 = 1'b0;
        do_op(1'b1, 1'b0, ge, oe, dn, f, z, ng, bc, ga, da);
        apply_reset();
        req0 = 1'b1; req1 = 1'b1;
        do_op(1'b1, 1'b0, ge, oe, dn, f, z, ng, bc, ga, da);
        m_ptr = 1'b1;
        checks++; if (ge !== 2'b01) begin failures++; $display("FAIL mid_ptr_reset: got %b want 01", ge); end
        req1 = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_random();
        logic [1:0] ge, dn, ga, da; logic [2:0] oe; logic [15:0] f; logic z, ng; int bc;
        logic [1:0] r;
        logic win;
        logic [15:0] ef;
        logic [2:0] eo;
        for (int unsigned i = 0; i < 40; i++) begin
            r = 2'($urandom_range(1, 3));
            req0 = r[0]; req1 = r[1];
            n0 = 16'($urandom); m0 = 16'($urandom); opc0 = 3'($urandom); c0 = 1'($urandom);
            n1 = 16'($urandom); m1 = 16'($urandom); opc1 = 3'($urandom); c1 = 1'($urandom);
            win = (r == 2'b11) ? m_ptr : r[1];
            ef = win ? (n1 + m1 + {15'd0, c1}) : (n0 + m0 + {15'd0, c0});
            eo = win ? opc1 : opc0;
            do_op(1'b1, 1'b0, ge, oe, dn, f, z, ng, bc, ga, da);
            m_ptr = ~win;
            checks++; if (ge !== (win ? 2'b10 : 2'b01)) begin failures++; $display("FAIL rand_gnt %0d: got %b want %b", i, ge, win ? 2'b10 : 2'b01); end
            checks++; if (dn !== (win ? 2'b10 : 2'b01)) begin failures++; $display("FAIL rand_done %0d: got %b want %b", i, dn, win ? 2'b10 : 2'b01); end
            checks++; if ({f, z, ng, oe} !== {ef, ef == 16'd0, ef[15], eo}) begin failures++; $display("FAIL rand_res %0d: got %h/%b/%b/%0d want %h/%b/%b/%0d", i, f, z, ng, oe, ef, ef == 16'd0, ef[15], eo); end
            checks++; if ({bc, ga, da} !== {32'd2, 4'b0000}) begin failures++; $display("FAIL rand_tail %0d: got busy=%0d gnt=%b done=%b want 2/00/00", i, bc, ga, da); end
        end
        req0 = 1'b0; req1 = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        n0 = '0; m0 = '0; n1 = '0; m1 = '0;
        opc0 = '0; opc1 = '0; c0 = 1'b0; c1 = 1'b0;
        m_ptr = 1'b0;
        #12;
        test_reset();
        test_single();
        test_simultaneous();
        test_isolation();
        test_opcode_sweep();
        test_late_request();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu16_arbiter.md
# alu16_arbiter

Two-requester round-robin arbiter and sequencer for the shared 16-bit signed ALU (ports n, m, opc, c -> f, zer, neg). It accepts operation requests from two clients, registers the winner's operands onto the ALU inputs, captures the combinational ALU result one cycle later, and returns it on a shared result bus with a per-client done pulse. It sits between the ALU instance and its users; the ALU itself stays purely combinational and outside this block.

## Interface
- No parameters; widths fixed at 16-bit data, 3-bit opcode, 2 requesters.
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- req0, req1  in  1 each  operation request from client 0 / client 1.
- n0, m0, n1, m1  in  16 each  signed operands per client; held stable while req is high.
- opc0, opc1  in  3 each  ALU opcode per client (all 8 codes passed through unmodified).
- c0, c1  in  1 each  carry-in per client.
- alu_n, alu_m  out  16  registered operands to the ALU.
- alu_opc  out  3  registered opcode to the ALU.
- alu_c  out  1  registered carry-in to the ALU.
- alu_f  in  16  ALU result (combinational from alu_* outputs).
- alu_zer, alu_neg  in  1 each  ALU flags.
- gnt  out  2  one-hot grant; bit i set while client i owns the ALU.
- done0, done1  out  1 each  one-cycle pulse: result for client i valid.
- res_f  out  16  captured result; res_zer, res_neg  out  1 each  captured flags.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE: if any req is high, pick a winner, latch its n/m/opc/c into alu_* registers, set gnt, and go to EXEC. Otherwise stay.
- Arbitration: a 1-bit priority pointer (reset = client 0).
  - If only one req is high, that client wins.
  - If both are high, the client named by the pointer wins.
  - After every grant, the pointer moves to the non-granted client.
- EXEC: the ALU evaluates latched operands. At the end of the cycle, capture alu_f/alu_zer/alu_neg into res_f/res_zer/res_neg and go to DONE.
- DONE: assert done for the granted client for exactly one cycle, then go to IDLE. Clear gnt on leaving DONE.
- Operand isolation: alu_* stay at the latched values from the grant until the next grant. Client input changes after the grant do not affect the result.
- Result hold: res_* hold their value until the next capture. Only done qualifies them.
- Client protocol: drop req on the edge at which done is sampled high. If req is still high in the following IDLE cycle, it is a new request and is arbitrated normally against the other client's pending request.
- Requests arriving during EXEC/DONE wait; they are never lost while held high.
- A request raised and dropped outside IDLE is ignored.

## Timing
- Latency: req high at IDLE edge k → operands on alu_* after edge k → result captured at edge k+1 → done high in the cycle after edge k+1 (visible at edge k+2).
- Throughput: one operation per 3 cycles. Back-to-back alternating clients get strictly alternating grants.
- Reset (asynchronous, any state, including mid-EXEC or DONE):
  - state = IDLE, pointer = 0.
  - gnt = 00, done0 = done1 = 0, busy = 0.
  - alu_n = alu_m = 0, alu_opc = 0, alu_c = 0.
  - res_f = 0, res_zer = 0, res_neg = 0.
  - An aborted operation produces no done.
- done0 and done1 are never high together. gnt is one-hot or zero. busy equals (state != IDLE).
- No arithmetic is done in this block; the 16-bit signed result and flags are copied bit-exact.

## Test plan
- Bench ALU stub: f = n+m+c, zer = (f==0), neg = f[15].
- Single request: req0 with n0=8, m0=3, opc0=0, c0=0 → gnt=01 in the next cycle, done0 two cycles later, res_f=11, zer=0, neg=0; busy high for 2 cycles.
- Simultaneous requests from reset: req0 and req1 high together, n1=-5, m1=2 → client 0 served first (res_f=11), then client 1 (res_f=-3, neg=1). Grants alternate 01, 10, 01 over three rounds with both requests held.
- Operand isolation: change n0 to 100 during EXEC → res_f is still 11.
- Opcode sweep: opc0 = 0..7 sequentially → alu_opc matches each code in its EXEC cycle. Zero result: n0=3, m0=-3 → zer=1.
- Reset mid-operation: deassert rst_n during EXEC → all outputs zero immediately, no done pulse. After release, req1 is served first only if req0 is low; otherwise pointer=0 gives client 0 priority.
